// File: rtl/gates_pkg.sv
// -----------------------------------------------------------------------------
// gates_pkg
// Shared constants for the board-level logic-gate demo. The board clock rate
// and the debounce window in milliseconds live here. msToCycles() turns a
// millisecond window into a clock-cycle count, and the top level uses it to
// size the debouncer.
// Ports: none (package).
// -----------------------------------------------------------------------------
package gates_pkg;

    localparam int CLK_FREQ_HZ = 32'sd100_000_000;
    localparam int DEBOUNCE_MS = 32'sd10;

    // Divide before multiplying so the product stays inside 32 bits.
    function automatic int msToCycles(input int ms);
        return ms * (CLK_FREQ_HZ / 32'sd1000);
    endfunction

endpackage : gates_pkg

// File: rtl/input_debouncer_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// Conditions one asynchronous switch line. It synchronises the line, debounces
// it and produces a clean level plus one-cycle rise/fall pulses.
// Ports:
//   clk       in   system clock
//   rstN      in   asynchronous active-low reset, clears every flop
//   rawIn     in   raw line, asynchronous to clk
//   outLevel  out  debounced registered level
//   outRise   out  one-cycle pulse on the edge where outLevel goes 0->1
//   outFall   out  one-cycle pulse on the edge where outLevel goes 1->0
// -----------------------------------------------------------------------------
module debounce_channel #(
    parameter int DEBOUNCE_CYCLES = 32'sd4
) (
    input  logic clk,
    input  logic rstN,
    input  logic rawIn,
    output logic outLevel,
    output logic outRise,
    output logic outFall
);

    // The counter only needs to reach DEBOUNCE_CYCLES-1, so clog2 is enough.
    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'sd1);

    logic             r_s1;
    logic             r_s2;
    logic             r_level;
    logic             r_rise;
    logic             r_fall;
    logic [CNT_W-1:0] r_cnt;
    logic             w_differ;
    logic             w_done;

    // Two-flop synchroniser; only r_s2 is used by any logic below.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= rawIn;
            r_s2 <= r_s1;
        end
    end

    // Disagreement flag, and the flag for the last cycle of a full stable window.
    always_comb begin
        w_differ = r_s2 ^ r_level;
        w_done   = 1'b0;
        if (w_differ && (r_cnt == CNT_LAST)) begin
            w_done = 1'b1;
        end else begin
            w_done = 1'b0;
        end
    end

    // Stability counter, level and pulse registers. A level change clears the
    // counter, so the counter never runs past CNT_LAST.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_cnt   <= {CNT_W{1'b0}};
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else if (!w_differ) begin
            r_cnt  <= {CNT_W{1'b0}};
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else if (w_done) begin
            r_cnt   <= {CNT_W{1'b0}};
            r_level <= r_s2;
            r_rise  <= r_s2;
            r_fall  <= ~r_s2;
        end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end
    end

    assign outLevel = r_level;
    assign outRise  = r_rise;
    assign outFall  = r_fall;

endmodule : debounce_channel

// File: rtl/input_debouncer.sv
// -----------------------------------------------------------------------------
// input_debouncer
// Upstream conditioning for the logic-gate demo: NUM_CH independent,
// identical debounce channels. outLevel[0] drives gates.inA and outLevel[1]
// drives gates.inB.
// Ports:
//   clk       in   system clock (100 MHz on board)
//   rstN      in   asynchronous active-low reset
//   rawIn     in   [NUM_CH] raw switch/button lines
//   outLevel  out  [NUM_CH] debounced registered levels
//   outRise   out  [NUM_CH] one-cycle 0->1 pulses
//   outFall   out  [NUM_CH] one-cycle 1->0 pulses
// -----------------------------------------------------------------------------
module input_debouncer
    import gates_pkg::*;
#(
    parameter int NUM_CH          = 32'sd2,
    parameter int DEBOUNCE_CYCLES = msToCycles(DEBOUNCE_MS)
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic [NUM_CH-1:0] rawIn,
    output logic [NUM_CH-1:0] outLevel,
    output logic [NUM_CH-1:0] outRise,
    output logic [NUM_CH-1:0] outFall
);

    logic [NUM_CH-1:0] w_level;
    logic [NUM_CH-1:0] w_rise;
    logic [NUM_CH-1:0] w_fall;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk     (clk),
            .rstN    (rstN),
            .rawIn   (rawIn[g]),
            .outLevel(w_level[g]),
            .outRise (w_rise[g]),
            .outFall (w_fall[g])
        );
    end

    assign outLevel = w_level;
    assign outRise  = w_rise;
    assign outFall  = w_fall;

endmodule : input_debouncer

// File: tb/tb_input_debouncer.sv
// -----------------------------------------------------------------------------
// tb_input_debouncer
// Directed scenarios followed by random bouncing, for DEBOUNCE_CYCLES=4 and
// NUM_CH=2. The reference model keeps a history of the raw samples taken at
// each edge. A channel's level flips when the D samples seen at the
// synchroniser output (the raw samples taken 2..D+1 edges ago) all disagree
// with the current level.
// -----------------------------------------------------------------------------
module tb_input_debouncer;

    localparam int D  = 4;
    localparam int NC = 2;

    logic          clk;
    logic          rstN;
    logic [NC-1:0] rawIn;
    logic [NC-1:0] outLevel;
    logic [NC-1:0] outRise;
    logic [NC-1:0] outFall;

    int n_vec;
    int n_err;

    // Reference model state.
    logic [NC-1:0] h [0:D+1];
    logic [NC-1:0] m_level;
    logic [NC-1:0] m_rise;
    logic [NC-1:0] m_fall;

    input_debouncer #(
        .NUM_CH(NC),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk     (clk),
        .rstN    (rstN),
        .rawIn   (rawIn),
        .outLevel(outLevel),
        .outRise (outRise),
        .outFall (outFall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i <= D + 1; i++) h[i] = '0;
        m_level = '0;
        m_rise  = '0;
        m_fall  = '0;
    endtask

    // Apply one raw value, clock one edge, update the model, then compare.
    task automatic step(input logic [NC-1:0] raw);
        logic all_diff;
        rawIn = raw;
        @(posedge clk);
        if (!rstN) begin
            model_reset();
        end else begin
            for (int i = D + 1; i > 0; i--) h[i] = h[i-1];
            h[0] = raw;
            for (int c = 0; c < NC; c++) begin
                all_diff = 1'b1;
                for (int j = 2; j <= D + 1; j++)
                    if (h[j][c] == m_level[c]) all_diff = 1'b0;
                m_rise[c] = all_diff & ~m_level[c];
                m_fall[c] = all_diff & m_level[c];
                if (all_diff) m_level[c] = ~m_level[c];
            end
        end
        #1;
        chk("outputs", 32'({outLevel, outRise, outFall}), 32'({m_level, m_rise, m_fall}));
    endtask

    // Asynchronous reset in mid-cycle: outputs must clear without any edge.
    task automatic async_reset(input string tag);
        rstN = 1'b0;
        #1;
        model_reset();
        chk(tag, 32'({outLevel, outRise, outFall}), 32'd0);
    endtask

    initial begin
        int e;
        int rises;
        int falls;
        logic [NC-1:0] r;
        n_vec = 0;
        n_err = 0;
        rstN  = 1'b0;
        rawIn = '0;
        model_reset();

        // 1. Reset: outputs are 0 before any clock edge, and while rstN stays low.
        #2;
        chk("reset_initial", 32'({outLevel, outRise, outFall}), 32'd0);
        for (int i = 0; i < 3; i++) step(2'b11);
        rstN = 1'b1;
        for (int i = 0; i < 8; i++) step(2'b11);
        chk("levels_high_before_reset", 32'(outLevel), 32'(2'b11));
        #2;
        async_reset("reset_async_midcycle");
        for (int i = 0; i < 3; i++) step(2'b11);
        rstN = 1'b1;
        // No power-up edge when rawIn is low after reset.
        for (int i = 0; i < 8; i++) step(2'b00);

        // 2. Clean press on channel 0.
        e = 0;
        do begin step(2'b01); e++; end while (outRise[0] !== 1'b1 && e < 20);
        chk("press_latency", 32'(e), 32'd6);
        chk("press_ch1_level", 32'(outLevel[1]), 32'd0);
        step(2'b01);
        chk("press_pulse_one_cycle", 32'(outRise[0]), 32'd0);

        // 3. Bounce on channel 1: 3-cycle pulses are rejected, the final 1 is accepted.
        rises = 0;
        falls = 0;
        for (int b = 0; b < 5; b++)
            for (int i = 0; i < 3; i++) begin
                step({((b % 2) == 0) ? 1'b1 : 1'b0, 1'b1});
                rises += int'(outRise[1]);
                falls += int'(outFall[1]);
            end
        for (int i = 0; i < 10; i++) begin
            step(2'b11);
            rises += int'(outRise[1]);
            falls += int'(outFall[1]);
        end
        chk("bounce_rises", 32'(rises), 32'd1);
        chk("bounce_falls", 32'(falls), 32'd0);

        // 4. Release on channel 0.
        e = 0;
        rises = 0;
        do begin step(2'b10); e++; rises += int'(outRise[0]); end
        while (outFall[0] !== 1'b1 && e < 20);
        chk("release_latency", 32'(e), 32'd6);
        chk("release_no_rise", 32'(rises), 32'd0);
        step(2'b10);
        chk("release_pulse_one_cycle", 32'(outFall[0]), 32'd0);

        // 5. Both channels rise on the same edge.
        for (int i = 0; i < 8; i++) step(2'b00);
        e = 0;
        do begin step(2'b11); e++; end while (outRise === 2'b00 && e < 20);
        chk("simul_rise", 32'({outRise, outLevel}), 32'(4'b1111));
        chk("simul_latency", 32'(e), 32'd6);

        // 6. Reset while the channel 0 count is at 2, then a fresh rise afterwards.
        for (int i = 0; i < 8; i++) step(2'b00);
        for (int i = 0; i < 4; i++) step(2'b01);
        #2;
        async_reset("reset_midcount");
        step(2'b01);
        rstN = 1'b1;
        e = 0;
        do begin step(2'b01); e++; end while (outRise[0] !== 1'b1 && e < 20);
        chk("postreset_rise_latency", 32'(e), 32'd6);

        // Random bouncing with an occasional reset.
        r = '0;
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < NC; c++)
                if ($urandom_range(0, 4) == 0) r[c] = ~r[c];
            if ($urandom_range(0, 199) == 0) begin
                #2;
                async_reset("random_reset");
                step(r);
                rstN = 1'b1;
            end else begin
                step(r);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_input_debouncer

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
- Upstream conditioning stage for the board-level logic-gate demo.
- Takes raw, asynchronous, bouncing switch/pushbutton lines and synchronizes each to the system clock.
- Debounces each line and emits a clean level plus one-cycle edge pulses.
- outLevel[0] drives gates.inA and outLevel[1] drives gates.inB in the top level.

Parameters:
- NUM_CH, 2: number of independent input channels; must be ≥1.
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required before the debounced level changes (10 ms at 100 MHz); must be ≥2.
- CNT_W, $clog2(DEBOUNCE_CYCLES): width of the per-channel stability counter; derived, never overridden.

Ports:
- clk  input  1  system clock, 100 MHz on board.
- rstN  input  1  asynchronous, active-low reset.
- rawIn  input  NUM_CH  raw switch/button lines, asynchronous to clk.
- outLevel  output  NUM_CH  debounced, registered level per channel.
- outRise  output  NUM_CH  one-cycle pulse when outLevel goes 0→1.
- outFall  output  NUM_CH  one-cycle pulse when outLevel goes 1→0.

Behaviour:
- Interface (already decided): one clock, clk. Reset rstN is asynchronous and active-low.
- Reset: while rstN=0, every flop is cleared, including sync stages, counters, outLevel, outRise and outFall. All outputs read 0 immediately, with no dependence on a clock edge.
- Reset release is used directly; no internal reset synchronizer is required.
- Channels are fully independent, and all channels are identical.
- Synchronizer: two-flop chain per channel, rawIn → s1 → s2. Only s2 is used downstream. rawIn never feeds combinational logic.
- Stability counter cnt (CNT_W bits), evaluated every clock:
  - s2 == outLevel: cnt ← 0; no output change.
  - s2 != outLevel and cnt < DEBOUNCE_CYCLES-1: cnt ← cnt+1.
  - s2 != outLevel and cnt == DEBOUNCE_CYCLES-1: outLevel ← s2 and cnt ← 0. outRise or outFall is asserted on the same edge, so the pulse and the new level are visible in the same cycle.
- Latency: a clean rawIn change sampled at edge k becomes visible on outLevel after edge k+DEBOUNCE_CYCLES+1, i.e. DEBOUNCE_CYCLES+2 clock edges in total.
- Glitch rejection: any return of s2 to the current outLevel before the count completes clears cnt, and no output change occurs. Pulses shorter than DEBOUNCE_CYCLES cycles at s2 are fully rejected. The count restarts from 0 on the next disagreement.
- Pulses:
  - outRise and outFall are registered and high for exactly one cycle per transition.
  - Per channel they are never high simultaneously.
  - Both are 0 in every cycle in which outLevel does not change.
- Counter never wraps: it saturates logically at DEBOUNCE_CYCLES-1 because it is cleared on the transition.
- Reset mid-count: the count is discarded and the level returns to 0. If rawIn is held high through and after reset, the channel sees a fresh 0→1: outRise fires DEBOUNCE_CYCLES+2 edges after the first post-reset edge.
- No power-up edge: after reset with rawIn=0, outRise and outFall stay 0.

Decomposition:
- Shared package gates_pkg holds:
  - CLK_FREQ_HZ = 100_000_000
  - DEBOUNCE_MS = 10
  - function msToCycles(ms), used to compute DEBOUNCE_CYCLES at top-level instantiation.
- Sub-module debounce_channel: a single-bit synchronizer, counter and edge-pulse unit.
- input_debouncer instantiates NUM_CH copies of debounce_channel in a generate loop and concatenates their outputs.

Test Plan (DEBOUNCE_CYCLES=4, NUM_CH=2, unless noted):
1. Reset: rstN=0 asserted mid-cycle with rawIn=2'b11 → all outputs are 0 immediately, asynchronously, and stay 0 while rstN=0.
2. Clean press: rawIn[0] goes 0→1 and is held; sampled at edge k → outLevel[0]=1 and outRise[0]=1 after edge k+5. outRise[0] returns to 0 after edge k+6. outLevel[1] stays 0 throughout.
3. Bounce rejection: rawIn[1] toggles 1,0,1,0,1 with each value held 3 cycles, then settles at 1 → no change until 4 consecutive s2=1 cycles. Exactly one outRise[1] pulse results, with no outFall[1].
4. Release: with outLevel[0]=1, rawIn[0] goes 1→0 at edge k → outFall[0] is a single-cycle pulse and outLevel[0]=0 after edge k+5. outRise[0] stays 0.
5. Simultaneous channels: both rawIn bits rise at the same edge → both outLevel bits and both outRise bits assert on the same cycle.
6. Reset mid-count: rawIn[0]=1, rstN pulsed low while cnt=2 → outputs 0. After release with rawIn[0] still 1, outRise[0] fires exactly 6 edges later.
